noise_burst_exciter: RTL and testbench
======================================

Name: noise_burst_exciter

Overview:
- Consumer stage for the 8-tap LFSR noise generator.
- On a note trigger, it selects one of the eight delayed signed 16-bit noise taps and scales it by a 7-bit velocity.
- It emits a finite excitation burst at audio-sample rate: a full-level body followed by a linear fade-out.
- The output feeds the string/delay-line loader that seeds each voice.

Parameters:
- BURST_LEN, 64: number of full-level samples in the burst body (min 1).
- FADE_SHIFT, 4: fade length is 2^FADE_SHIFT samples (min 1).

Ports:
- clk, input, 1: system clock; all state on rising edge.
- reset, input, 1: asynchronous, active-low reset.
- sample_en, input, 1: one-clk strobe per audio sample; paces all sample output.
- trig, input, 1: note-on; sampled every clk.
- velocity, input, 7: unsigned note velocity, 0..127; latched on accepted trig.
- voice_sel, input, 3: selects noise tap k, 0..7; latched on accepted trig.
- noise_bus, input, 128: eight signed 16-bit noise taps; lane k = bits [16k+15:16k].
- exc_out, output, 16: signed excitation sample; registered.
- exc_valid, output, 1: one-clk pulse when exc_out is updated.
- busy, output, 1: high in BURST or FADE.
- done, output, 1: one-clk pulse when the burst completes.

Behaviour:
- Reset, asserted asynchronously:
  - state=IDLE; exc_out=0, exc_valid=0, busy=0, done=0.
  - Latched velocity, latched voice and counters cleared.
  - Release is synchronous to clk. Reset mid-burst aborts without a done pulse.
- States: IDLE, BURST, FADE, DONE. busy = (state==BURST or FADE), decoded from registered state.
- IDLE:
  - trig=1 latches velocity and voice_sel, clears sample counter i, and moves to BURST.
  - If sample_en coincides with the accepted trig, no sample is emitted that cycle. The first sample comes on the next sample_en.
- Retrigger: trig=1 in BURST or FADE re-latches velocity/voice, clears i, and goes to BURST. Any sample_en that same cycle is ignored; no done pulse.
- BURST: on each sample_en (no trig):
  - scaled = (noise_k * {1'b0,vel}) >>> 7, computed with a 24-bit signed product and arithmetic (floor) shift, no rounding. Result fits in 16 bits.
  - exc_out <= scaled; exc_valid=1 the next clk after sample_en (1-clk latency).
  - i increments. After the BURST_LEN-th sample: i=0, go to FADE.
- FADE: on each sample_en:
  - gain g = 2^FADE_SHIFT - i, so g runs 2^FADE_SHIFT down to 1.
  - exc_out <= (scaled * g) >>> FADE_SHIFT, computed in full precision with a floor shift.
  - i increments. After the 2^FADE_SHIFT-th sample, go to DONE.
- DONE:
  - Lasts exactly one clk: done=1, exc_out<=0 (no exc_valid), then go to IDLE.
  - A trig in the DONE cycle is ignored.
- Sampling timing:
  - noise_bus is sampled on the sample_en cycle, with the lane fixed by the latched voice.
  - Tap contents may change freely between strobes.
- Outputs when idle:
  - exc_out holds 0 in IDLE.
  - exc_valid never pulses outside BURST/FADE.
- Edge cases:
  - velocity=0: the full burst still runs and all outputs are 0.
  - No sample_en: state holds indefinitely.
- Counter sizing: counter width is ceil(log2(max(BURST_LEN, 2^FADE_SHIFT)+1)). No wrap is possible within a state.

Test Plan:
1. Reset with outputs toggling, then release → exc_out=0, exc_valid=0, busy=0, done=0. Assert reset mid-BURST → immediate IDLE, no done pulse.
2. BURST_LEN=4, FADE_SHIFT=2; lane3=16'h4000, voice_sel=3, vel=64 → 4 samples of 16'h2000, then fade 16'h2000, 16'h1800, 16'h1000, 16'h0800. Then a done pulse 1 clk after the last sample; busy low after.
3. Lane0=16'hC000, vel=127 → each burst sample = 16'hC080 (-16256). Lane0=16'hFFFF, vel=1 → 16'hFFFF (floor).
4. trig coincident with sample_en in IDLE → no exc_valid that cycle; first exc_valid one clk after the next sample_en.
5. Retrigger at fade sample 2 with vel=32, lane5=16'h4000 → no done pulse; a new full 4-sample burst of 16'h1000 follows, then a full fade.
6. vel=0, random noise_bus, sample_en every 3 clks → 8 exc_valid pulses, all exc_out=0, done pulses once. exc_valid is always exactly 1 clk after sample_en.

Source files
------------

// File: rtl/noise_burst_exciter.sv
// noise_burst_exciter
//   On a note trigger, picks one of eight signed 16-bit noise taps and scales
//   it by the note velocity. It then emits a finite excitation burst at the
//   audio sample rate: BURST_LEN full-level samples, followed by a linear
//   fade-out of 2^FADE_SHIFT samples. The output seeds a voice's
//   string/delay-line loader.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   sample_en  one-clk strobe per audio sample
//   trig       note-on, sampled every clk
//   velocity   unsigned note velocity, latched on an accepted trig
//   voice_sel  noise tap select, latched on an accepted trig
//   noise_bus  eight signed 16-bit taps; lane k = [16k+15:16k]
//   exc_out    registered signed excitation sample
//   exc_valid  one-clk pulse when exc_out is updated by a sample
//   busy       high while in BURST or FADE
//   done       one-clk pulse when a burst completes
module noise_burst_exciter #(
  parameter int BURST_LEN  = 64,
  parameter int FADE_SHIFT = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_en,
  input  logic               trig,
  input  logic [6:0]         velocity,
  input  logic [2:0]         voice_sel,
  input  logic [127:0]       noise_bus,
  output logic signed [15:0] exc_out,
  output logic               exc_valid,
  output logic               busy,
  output logic               done
);

  localparam int FADE_LEN = 1 << FADE_SHIFT;
  localparam int MAX_LEN  = (BURST_LEN > FADE_LEN) ? BURST_LEN : FADE_LEN;
  localparam int CNT_W    = $clog2(MAX_LEN + 1);
  localparam int GW       = FADE_SHIFT + 1;
  localparam int FW       = 16 + GW;

  localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [CNT_W-1:0] FADE_LAST  = CNT_W'(FADE_LEN - 1);
  localparam logic [CNT_W-1:0] FADE_TOP   = CNT_W'(FADE_LEN);

  typedef enum logic [1:0] {S_IDLE, S_BURST, S_FADE, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [6:0]         vel_q, vel_d;
  logic [2:0]         voice_q, voice_d;
  logic signed [15:0] exc_out_q, exc_out_d;
  logic               exc_valid_q, exc_valid_d;
  logic               done_q, done_d;

  logic signed [15:0] lane;
  logic signed [15:0] scaled;
  logic signed [15:0] faded;
  logic [GW-1:0]      gain;

  // Velocity scaling: 24-bit signed product, floor shift by 7, no rounding.
  // The result always fits in 16 bits because velocity < 128.
  function automatic logic signed [15:0] vel_scale(input logic signed [15:0] x,
                                                   input logic [6:0] v);
    logic signed [23:0] xe;
    logic signed [23:0] ve;
    logic signed [23:0] p;
    xe = {{8{x[15]}}, x};
    ve = {17'd0, v};
    p  = xe * ve;
    return 16'(p >>> 7);
  endfunction

  // Fade gain: full-precision product, floor shift by FADE_SHIFT. The gain
  // never exceeds 2^FADE_SHIFT, so the magnitude never grows.
  function automatic logic signed [15:0] fade_scale(input logic signed [15:0] x,
                                                    input logic [GW-1:0] g);
    logic signed [FW-1:0] xe;
    logic signed [FW-1:0] ge;
    logic signed [FW-1:0] p;
    xe = {{GW{x[15]}}, x};
    ge = {16'd0, g};
    p  = xe * ge;
    return 16'(p >>> FADE_SHIFT);
  endfunction

  always_comb begin
    lane   = noise_bus[{voice_q, 4'b0000} +: 16];
    scaled = vel_scale(lane, vel_q);
    gain   = GW'(FADE_TOP - cnt_q);
    faded  = fade_scale(scaled, gain);

    state_d     = state_q;
    cnt_d       = cnt_q;
    vel_d       = vel_q;
    voice_d     = voice_q;
    exc_out_d   = exc_out_q;
    exc_valid_d = 1'b0;
    done_d      = 1'b0;

    case (state_q)
      S_IDLE: begin
        exc_out_d = '0;
        // A sample_en coinciding with the trig is deliberately dropped.
        if (trig) begin
          vel_d   = velocity;
          voice_d = voice_sel;
          cnt_d   = '0;
          state_d = S_BURST;
        end
      end
      S_BURST, S_FADE: begin
        if (trig) begin
          // Retrigger restarts the body; any same-cycle strobe is dropped.
          vel_d   = velocity;
          voice_d = voice_sel;
          cnt_d   = '0;
          state_d = S_BURST;
        end else if (sample_en) begin
          exc_valid_d = 1'b1;
          if (state_q == S_BURST) begin
            exc_out_d = scaled;
            if (cnt_q == BURST_LAST) begin
              cnt_d   = '0;
              state_d = S_FADE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end else begin
            exc_out_d = faded;
            if (cnt_q == FADE_LAST) begin
              cnt_d   = '0;
              state_d = S_DONE;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        // Trig is ignored here; the done pulse lands one clk after the last sample.
        done_d    = 1'b1;
        exc_out_d = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      vel_q       <= '0;
      voice_q     <= '0;
      exc_out_q   <= '0;
      exc_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      vel_q       <= vel_d;
      voice_q     <= voice_d;
      exc_out_q   <= exc_out_d;
      exc_valid_q <= exc_valid_d;
      done_q      <= done_d;
    end
  end

  assign exc_out   = exc_out_q;
  assign exc_valid = exc_valid_q;
  assign done      = done_q;
  assign busy      = (state_q == S_BURST) || (state_q == S_FADE);

endmodule

// File: tb/tb_noise_burst_exciter.sv
// Directed testbench for noise_burst_exciter with BURST_LEN=4, FADE_SHIFT=2.
module tb_noise_burst_exciter;

  logic               clk;
  logic               reset;
  logic               sample_en;
  logic               trig;
  logic [6:0]         velocity;
  logic [2:0]         voice_sel;
  logic [127:0]       noise_bus;
  logic signed [15:0] exc_out;
  logic               exc_valid;
  logic               busy;
  logic               done;

  int errs;
  int checks;
  logic mon_en;
  int vcnt;
  int dcnt;

  noise_burst_exciter #(.BURST_LEN(4), .FADE_SHIFT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .trig      (trig),
    .velocity  (velocity),
    .voice_sel (voice_sel),
    .noise_bus (noise_bus),
    .exc_out   (exc_out),
    .exc_valid (exc_valid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse counters for windowed checks; cleared whenever the window is closed.
  always @(negedge clk) begin
    if (!mon_en) begin
      vcnt = 0;
      dcnt = 0;
    end else begin
      if (exc_valid) vcnt = vcnt + 1;
      if (done) dcnt = dcnt + 1;
    end
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      errs = errs + 1;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input string tag, input logic [15:0] exp);
    sample_en = 1'b1;
    step();
    sample_en = 1'b0;
    check({tag, "_vld"}, {15'd0, exc_valid}, 16'd1);
    check(tag, exc_out, exp);
  endtask

  task automatic arm(input string tag, input logic [6:0] vel, input logic [2:0] voice);
    velocity  = vel;
    voice_sel = voice;
    trig      = 1'b1;
    step();
    trig      = 1'b0;
    check({tag, "_busy"}, {15'd0, busy}, 16'd1);
  endtask

  task automatic burst_seq(input string tag, input int nb, input logic [15:0] b,
                           input logic [15:0] f0, input logic [15:0] f1,
                           input logic [15:0] f2, input logic [15:0] f3);
    for (int k = 0; k < nb; k++) strobe({tag, "_body"}, b);
    strobe({tag, "_fade0"}, f0);
    strobe({tag, "_fade1"}, f1);
    strobe({tag, "_fade2"}, f2);
    strobe({tag, "_fade3"}, f3);
    check({tag, "_done_early"}, {15'd0, done}, 16'd0);
    step();
    check({tag, "_done"}, {15'd0, done}, 16'd1);
    check({tag, "_done_vld"}, {15'd0, exc_valid}, 16'd0);
    check({tag, "_done_out"}, exc_out, 16'h0000);
    check({tag, "_done_busy"}, {15'd0, busy}, 16'd0);
    step();
    check({tag, "_done_end"}, {15'd0, done}, 16'd0);
    check({tag, "_idle_busy"}, {15'd0, busy}, 16'd0);
  endtask

  initial begin
    errs      = 0;
    checks    = 0;
    mon_en    = 1'b0;
    reset     = 1'b0;
    sample_en = 1'b0;
    trig      = 1'b0;
    velocity  = '0;
    voice_sel = '0;
    noise_bus = '0;

    // Reset state
    step();
    step();
    check("rst_out", exc_out, 16'h0000);
    check("rst_vld", {15'd0, exc_valid}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_done", {15'd0, done}, 16'd0);
    reset = 1'b1;
    step();

    // Reset asserted mid-burst with exc_valid high
    mon_en = 1'b1;
    noise_bus[63:48] = 16'h4000;
    arm("mid", 7'd64, 3'd3);
    strobe("mid_s0", 16'h2000);
    strobe("mid_s1", 16'h2000);
    #3 reset = 1'b0;
    #1;
    check("mid_rst_vld", {15'd0, exc_valid}, 16'd0);
    check("mid_rst_busy", {15'd0, busy}, 16'd0);
    check("mid_rst_out", exc_out, 16'h0000);
    step();
    reset = 1'b1;
    step();
    step();
    step();
    check("mid_no_done", dcnt[15:0], 16'd0);
    check("mid_idle_busy", {15'd0, busy}, 16'd0);
    mon_en = 1'b0;
    step();

    // Basic burst and fade
    arm("basic", 7'd64, 3'd3);
    burst_seq("basic", 4, 16'h2000, 16'h2000, 16'h1800, 16'h1000, 16'h0800);

    // Negative tap, full velocity; fade floors toward minus infinity
    noise_bus[15:0] = 16'hC000;
    arm("neg", 7'd127, 3'd0);
    burst_seq("neg", 4, 16'hC080, 16'hC080, 16'hD060, 16'hE040, 16'hF020);

    // -1 at velocity 1 stays -1 throughout
    noise_bus[15:0] = 16'hFFFF;
    arm("floor", 7'd1, 3'd0);
    burst_seq("floor", 4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);

    // trig coincident with sample_en in IDLE
    noise_bus[47:32] = 16'h2000;
    velocity  = 7'd127;
    voice_sel = 3'd2;
    trig      = 1'b1;
    sample_en = 1'b1;
    step();
    trig      = 1'b0;
    sample_en = 1'b0;
    check("coin_vld", {15'd0, exc_valid}, 16'd0);
    check("coin_busy", {15'd0, busy}, 16'd1);
    step();
    check("coin_gap_vld", {15'd0, exc_valid}, 16'd0);
    strobe("coin_first", 16'h1FC0);
    burst_seq("coin", 3, 16'h1FC0, 16'h1FC0, 16'h17D0, 16'h0FE0, 16'h07F0);

    // Retrigger in FADE with a coincident strobe
    mon_en = 1'b1;
    arm("retrig_a", 7'd64, 3'd3);
    for (int k = 0; k < 4; k++) strobe("retrig_body", 16'h2000);
    strobe("retrig_f0", 16'h2000);
    strobe("retrig_f1", 16'h1800);
    noise_bus[95:80] = 16'h4000;
    velocity  = 7'd32;
    voice_sel = 3'd5;
    trig      = 1'b1;
    sample_en = 1'b1;
    step();
    trig      = 1'b0;
    sample_en = 1'b0;
    check("retrig_vld", {15'd0, exc_valid}, 16'd0);
    check("retrig_done", {15'd0, done}, 16'd0);
    check("retrig_busy", {15'd0, busy}, 16'd1);
    burst_seq("retrig_b", 4, 16'h1000, 16'h1000, 16'h0C00, 16'h0800, 16'h0400);
    check("retrig_done_cnt", dcnt[15:0], 16'd1);
    mon_en = 1'b0;
    step();

    // Velocity 0, random taps, sample_en every third clk
    mon_en = 1'b1;
    noise_bus = {$urandom, $urandom, $urandom, $urandom};
    arm("zero", 7'd0, 3'($urandom_range(0, 7)));
    for (int k = 0; k < 8; k++) begin
      noise_bus = {$urandom, $urandom, $urandom, $urandom};
      strobe("zero_s", 16'h0000);
      step();
      check("zero_gap_vld", {15'd0, exc_valid}, 16'd0);
      step();
    end
    step();
    step();
    check("zero_vcnt", vcnt[15:0], 16'd8);
    check("zero_dcnt", dcnt[15:0], 16'd1);
    check("zero_busy", {15'd0, busy}, 16'd0);
    check("zero_out", exc_out, 16'h0000);
    mon_en = 1'b0;

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
